// File: rtl/value_ram_arb.sv
// value_ram_arb: zero-fill sequencer, write pass-through and RR read arbiter for the FIX value RAM.
// Optional same-cycle write-to-read bypass: define VALUE_RAM_ARB_BYPASS_EN.
module value_ram_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_req,
  output logic                         init_done,
  input  logic                         wr_req,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_gnt,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [ADDR_WIDTH-1:0]        ram_addr_0,
  output logic [DATA_WIDTH-1:0]        ram_wdata_0,
  output logic                         ram_cs_0,
  output logic                         ram_we_0,
  output logic                         ram_oe_0,
  output logic [ADDR_WIDTH-1:0]        ram_addr_1,
  output logic                         ram_cs_1,
  output logic                         ram_we_1,
  output logic                         ram_oe_1,
  input  logic [DATA_WIDTH-1:0]        ram_rdata_1
);

  localparam int PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_id1;
  logic [PW-1:0]         r_id2;
  logic                  r_v1;
  logic                  r_v2;
  logic [DATA_WIDTH-1:0] r_data2;
  logic                  w_run;
  logic                  w_any;
  logic [PW-1:0]         w_idx;
  logic [ADDR_WIDTH-1:0] w_gaddr;
  logic [DATA_WIDTH-1:0] w_rdsel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // Next state: sweep ends on the all-ones address; clear restarts it
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT: if (&r_cnt) w_next = S_RUN;
      S_RUN:  if (clr_req) w_next = S_INIT;
      default: w_next = S_INIT;
    endcase
  end

  // Port-0 outputs: zero-fill sweep in INIT, writer pass-through in RUN
  always_comb begin
    w_run       = (r_state == S_RUN);
    init_done   = w_run;
    wr_gnt      = w_run & wr_req;
    ram_oe_0    = 1'b0;
    ram_cs_0    = 1'b1;
    ram_we_0    = 1'b1;
    ram_addr_0  = r_cnt;
    ram_wdata_0 = '0;
    if (w_run) begin
      ram_cs_0    = wr_req;
      ram_we_0    = wr_req;
      ram_addr_0  = wr_addr;
      ram_wdata_0 = wr_req ? wr_data : '0;
    end
  end

  // Sweep counter; parked at zero while running so each sweep starts at 0
  always_ff @(posedge clk) begin
    if (reset || r_state == S_RUN) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end

  // Round-robin search starting at the pointer
  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    w_any = 1'b0;
    w_idx = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_RD) j = j - NUM_RD;
      jj = PW'(j);
      if (w_run && !w_any && rd_req[jj]) begin
        w_any = 1'b1;
        w_idx = jj;
      end
    end
  end

  // Port-1 drive: enables held through T+1 so the tristated data is live when sampled
  always_comb begin
    w_gaddr    = rd_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    rd_gnt     = w_any ? (NUM_RD'(1) << w_idx) : '0;
    rd_valid   = r_v2 ? (NUM_RD'(1) << r_id2) : '0;
    rd_data    = r_v2 ? r_data2 : '0;
    ram_addr_1 = w_any ? w_gaddr : r_addr1;
    ram_cs_1   = w_any | r_v1;
    ram_oe_1   = w_any | r_v1;
    ram_we_1   = 1'b0;
  end

`ifdef VALUE_RAM_ARB_BYPASS_EN
  logic                  r_byp1;
  logic [DATA_WIDTH-1:0] r_bypd1;

  // Capture a same-address write alongside the read grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byp1  <= 1'b0;
      r_bypd1 <= '0;
    end else begin
      r_byp1  <= w_any & wr_gnt & (wr_addr == w_gaddr);
      r_bypd1 <= wr_data;
    end
  end

  // Bypass word wins over the RAM's old data
  always_comb w_rdsel = r_byp1 ? r_bypd1 : ram_rdata_1;
`else
  // RAM data straight through
  always_comb w_rdsel = ram_rdata_1;
`endif

  // Read pipeline and RR pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_addr1 <= '0;
      r_v1    <= 1'b0;
      r_id1   <= '0;
      r_v2    <= 1'b0;
      r_id2   <= '0;
      r_data2 <= '0;
    end else begin
      r_v1  <= w_any;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      if (w_any) begin
        r_ptr   <= (w_idx == PW'(NUM_RD - 1)) ? '0 : w_idx + PW'(1);
        r_addr1 <= w_gaddr;
        r_id1   <= w_idx;
      end
      if (r_v1) r_data2 <= w_rdsel;
    end
  end

endmodule

// File: tb/tb_value_ram_arb.sv
// tb_value_ram_arb: directed test of value_ram_arb with a behavioural dual-port RAM.
// Expected read data depends on VALUE_RAM_ARB_BYPASS_EN.
module tb_value_ram_arb;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           clr_req;
  logic           init_done;
  logic           wr_req;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_gnt;
  logic [NR-1:0]  rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]  rd_gnt;
  logic [NR-1:0]  rd_valid;
  logic [DW-1:0]  rd_data;
  logic [AW-1:0]  ram_addr_0;
  logic [DW-1:0]  ram_wdata_0;
  logic           ram_cs_0, ram_we_0, ram_oe_0;
  logic [AW-1:0]  ram_addr_1;
  logic           ram_cs_1, ram_we_1, ram_oe_1;
  wire  [DW-1:0]  ram_rdata_1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  value_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr_0(ram_addr_0), .ram_wdata_0(ram_wdata_0),
    .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
    .ram_addr_1(ram_addr_1), .ram_cs_1(ram_cs_1),
    .ram_we_1(ram_we_1), .ram_oe_1(ram_oe_1), .ram_rdata_1(ram_rdata_1)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q;

  always @(posedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
    if (ram_cs_1 && !ram_we_1) q <= mem[ram_addr_1];
  end

  assign ram_rdata_1 = (ram_cs_1 && ram_oe_1 && !ram_we_1) ? q : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic set_ra(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  int nw;
  logic [DW-1:0] exp_same;

  initial begin
    reset = 1'b1; clr_req = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    rd_req = 4'b1111;
    settle();
    for (int i = 0; i < 64; i++) begin
      chk("init_addr0", ram_addr_0, i);
      chk("init_wdata0", ram_wdata_0, 0);
      chk("init_cswe0", {ram_cs_0, ram_we_0, ram_oe_0}, 3'b110);
      chk("init_rd_gnt", rd_gnt, 0);
      chk("init_wr_gnt", wr_gnt, 0);
      chk("init_done_low", init_done, 0);
      if (i == 63) rd_req = '0;
      tick();
    end
    chk("init_done_rise", init_done, 1);

    wr_req = 1'b1; wr_addr = 6'd5; wr_data = 8'hA3;
    settle();
    chk("wr_gnt", wr_gnt, 1);
    chk("wr_port0", {ram_cs_0, ram_we_0, ram_oe_0}, 3'b110);
    chk("wr_addr0", ram_addr_0, 5);
    chk("wr_wdata0", ram_wdata_0, 8'hA3);
    tick();
    wr_req = 1'b0;
    settle();
    chk("wr_idle_port0", {ram_cs_0, ram_we_0, ram_wdata_0}, 0);
    set_ra(2, 6'd5);
    rd_req = 4'b0100;
    settle();
    chk("rd2_gnt", rd_gnt, 4'b0100);
    chk("rd2_addr1", ram_addr_1, 5);
    chk("rd2_csoe", {ram_cs_1, ram_oe_1, ram_we_1}, 3'b110);
    tick();
    rd_req = '0;
    settle();
    chk("rd2_t1_valid", rd_valid, 0);
    chk("rd2_t1_csoe", {ram_cs_1, ram_oe_1}, 2'b11);
    chk("rd2_t1_addr1", ram_addr_1, 5);
    tick();
    chk("rd2_valid", rd_valid, 4'b0100);
    chk("rd2_data", rd_data, 8'hA3);
    chk("rd2_t2_csoe", {ram_cs_1, ram_oe_1}, 2'b00);
    tick();
    chk("rd2_after_valid", rd_valid, 0);
    chk("rd2_after_data", rd_data, 0);

    set_ra(3, 6'd5);
    rd_req = 4'b1000;
    settle();
    chk("rd3_gnt", rd_gnt, 4'b1000);
    tick();
    rd_req = '0;
    tick();
    chk("rd3_valid", rd_valid, 4'b1000);
    chk("rd3_data", rd_data, 8'hA3);

    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = AW'(6'h10 + i); wr_data = DW'(8'hC0 + i);
      tick();
    end
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) set_ra(i, AW'(6'h10 + i));
    for (int k = 0; k < 7; k++) begin
      rd_req = (k < 5) ? 4'b1111 : 4'b0000;
      settle();
      chk("rr_gnt", rd_gnt, (k < 5) ? (32'd1 << (k % 4)) : 0);
      if (k >= 2) begin
        chk("rr_valid", rd_valid, 32'd1 << ((k - 2) % 4));
        chk("rr_data", rd_data, 8'hC0 + ((k - 2) % 4));
      end else begin
        chk("rr_valid_early", rd_valid, 0);
      end
      tick();
    end
    rd_req = '0;

    wr_req = 1'b1; wr_addr = 6'd9; wr_data = 8'h11;
    tick();
    wr_addr = 6'd9; wr_data = 8'h55;
    set_ra(0, 6'd9);
    rd_req = 4'b0001;
    settle();
    chk("same_wr_gnt", wr_gnt, 1);
    chk("same_rd_gnt", rd_gnt, 4'b0001);
    tick();
    wr_req = 1'b0; rd_req = '0;
    tick();
`ifdef VALUE_RAM_ARB_BYPASS_EN
    exp_same = 8'h55;
`else
    exp_same = 8'h11;
`endif
    chk("same_valid", rd_valid, 4'b0001);
    chk("same_data", rd_data, exp_same);
    set_ra(1, 6'd9);
    rd_req = 4'b0010;
    settle();
    chk("after_wr_gnt", rd_gnt, 4'b0010);
    tick();
    rd_req = '0;
    tick();
    chk("after_wr_data", rd_data, 8'h55);

    set_ra(0, 6'h10);
    rd_req = 4'b0001;
    settle();
    chk("clr_rd0_gnt", rd_gnt, 4'b0001);
    tick();
    set_ra(1, 6'h11);
    rd_req = 4'b0010;
    clr_req = 1'b1;
    settle();
    chk("clr_rd1_gnt", rd_gnt, 4'b0010);
    chk("clr_done_hi", init_done, 1);
    tick();
    clr_req = 1'b0; rd_req = '0;
    settle();
    chk("clr_done_fall", init_done, 0);
    chk("clr_v0", rd_valid, 4'b0001);
    chk("clr_d0", rd_data, 8'hC0);
    chk("clr_hold_csoe", {ram_cs_1, ram_oe_1}, 2'b11);
    chk("clr_sweep_addr", ram_addr_0, 0);
    tick();
    chk("clr_v1", rd_valid, 4'b0010);
    chk("clr_d1", rd_data, 8'hC1);
    wait_init(nw);
    chk("reinit_len", nw, 63);
    set_ra(2, 6'h10);
    rd_req = 4'b0100;
    settle();
    chk("reinit_rd_gnt", rd_gnt, 4'b0100);
    tick();
    rd_req = '0;
    tick();
    chk("reinit_valid", rd_valid, 4'b0100);
    chk("reinit_data", rd_data, 0);

    set_ra(3, 6'h11);
    rd_req = 4'b1000;
    settle();
    chk("rst_rd_gnt", rd_gnt, 4'b1000);
    tick();
    reset = 1'b1; rd_req = '0;
    tick();
    reset = 1'b0;
    settle();
    chk("rst_flush_valid", rd_valid, 0);
    chk("rst_state_init", init_done, 0);
    chk("rst_cs1", ram_cs_1, 0);
    chk("rst_addr0", ram_addr_0, 0);
    tick();
    chk("rst_flush_valid2", rd_valid, 0);
    wait_init(nw);
    chk("rst_init_len", nw, 63);
    rd_req = 4'b1111;
    settle();
    chk("rst_ptr0", rd_gnt, 4'b0001);
    tick();
    rd_req = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/value_ram_arb.md
Name: value_ram_arb

Overview:
- Front-end controller for the dual-port FIX value RAM.
- After reset, or on request, it zero-fills the whole array by sweeping port 0.
- It then passes one parser writer straight onto port 0 and round-robins NUM_RD field-lookup readers onto port 1.
- It sequences the port-1 chip-select and output-enable so the RAM's registered, tristated read data is driven when sampled, and returns each result tagged to the reader that issued it.

Parameters:
- ADDR_WIDTH, 6, RAM address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- NUM_RD, 4, number of reader requesters (>= 2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- clr_req  input  1  pulse in RUN: re-zero the RAM.
- init_done  output  1  high in RUN.
- wr_req  input  1  writer request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_gnt  output  1  write accepted this cycle.
- rd_req  input  NUM_RD  per-reader request; held with address until granted.
- rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; reader i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_gnt  output  NUM_RD  one-hot read grant.
- rd_valid  output  NUM_RD  one-hot read-data-valid.
- rd_data  output  DATA_WIDTH  read data, qualified by rd_valid.
- ram_addr_0  output  ADDR_WIDTH  RAM port-0 address.
- ram_wdata_0  output  DATA_WIDTH  RAM port-0 write data (drives the data_0 net).
- ram_cs_0, ram_we_0, ram_oe_0  output  1 each  RAM port-0 controls.
- ram_addr_1  output  ADDR_WIDTH  RAM port-1 address.
- ram_cs_1, ram_we_1, ram_oe_1  output  1 each  RAM port-1 controls.
- ram_rdata_1  input  DATA_WIDTH  RAM port-1 data net.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = INIT, init counter = 0, RR pointer = 0, read pipeline empty.
  - init_done = 0; rd_valid = 0; rd_data = 0.
- States:
  - INIT:
    - Each cycle: ram_cs_0 = 1, ram_we_0 = 1, ram_oe_0 = 0, ram_addr_0 = counter, ram_wdata_0 = 0; counter++.
    - When counter == RAM_DEPTH-1 (all ones), that write completes and the next state is RUN with counter = 0.
    - INIT lasts exactly RAM_DEPTH cycles. wr_gnt = 0 and rd_gnt = 0 throughout.
  - RUN:
    - init_done = 1.
    - clr_req = 1 moves to INIT next cycle. That cycle's wr/rd grants are still honoured.
    - clr_req is ignored in INIT.
- Write path (RUN only):
  - wr_gnt = wr_req, combinational.
  - When granted: ram_cs_0 = ram_we_0 = 1, ram_addr_0 = wr_addr, ram_wdata_0 = wr_data.
  - When not granted: ram_cs_0 = ram_we_0 = 0 and ram_wdata_0 = 0.
  - ram_oe_0 = 0 always.
- Port 1 is read-only: ram_we_1 = 0 always.
- Read arbitration (RUN only), combinational:
  - Grant the first asserted rd_req at or after the RR pointer, wrapping modulo NUM_RD. At most one grant per cycle.
  - On a grant to reader i, the pointer becomes (i+1) mod NUM_RD at the next edge; otherwise the pointer is unchanged.
- Read pipeline (grant in cycle T):
  - T: ram_addr_1 = granted address; ram_cs_1 = ram_oe_1 = 1.
  - T+1: the RAM output is driven only while cs_1 && oe_1 && !we_1. The controller therefore holds ram_cs_1 = ram_oe_1 = 1 in T+1, with ram_addr_1 unchanged if there is no new grant. The redundant re-read is harmless. ram_rdata_1 is sampled at the end of T+1.
  - T+2: rd_valid[i] = 1 for one cycle; rd_data = sampled word.
  - Grant-to-valid latency is 2 cycles; back-to-back grants give one result per cycle.
  - With no grant in T or T-1: ram_cs_1 = ram_oe_1 = 0 and ram_addr_1 holds its last value.
  - When rd_valid = 0, rd_data = 0.
- Same-cycle write and read to the same address: the read returns the old word; the new word is visible to reads granted from the cycle after the write.
- A clr_req accepted while reads are in flight: those reads drain normally, and ram_cs_1/ram_oe_1 are held for their T+1 cycles even in INIT.
- reset mid-operation: the pipeline is flushed and no rd_valid is issued for reads already in flight.

Optional Feature:
- Macro: VALUE_RAM_ARB_BYPASS_EN.
- Defined:
  - A read granted in the same cycle as a granted write to the same address returns wr_data on rd_valid, with latency still 2.
  - The bypass word is captured in cycle T alongside the grant, and selected in place of ram_rdata_1 at the end of T+1.
- Undefined: old-data behaviour as above; no bypass logic is present.

Test Plan:
- Reset, then idle: init_done rises exactly 64 cycles after reset deasserts; ram_wdata_0 = 0 at every address 0..63; rd_gnt stays 0 during INIT even with rd_req = 4'b1111.
- Write addr 5 = 8'hA3, then reader 2 reads addr 5: rd_gnt = 4'b0100 in T; rd_valid = 4'b0100 and rd_data = 8'hA3 in T+2.
- rd_req = 4'b1111 held, with per-reader addresses preloaded to 8'h10..8'h13: grants cycle 0,1,2,3,0; the rd_valid/rd_data sequence matches, one per cycle.
- In the same cycle, write addr 9 = 8'h55 (old 8'h11) and reader 0 reads addr 9: rd_data = 8'h11 without the macro, 8'h55 with it.
- clr_req in RUN with two reads in flight: both rd_valid pulses are delivered; init_done falls next cycle; a read after re-init returns 0.
- reset asserted the cycle after a grant: no rd_valid follows; state is INIT; the pointer restarts at reader 0.
